smbus_mailbox_avmm_bridge: RTL and testbench

- Translates byte-level events from the SMBus target PHY (address already matched) into single-beat AVMM-like transactions on one SMBus port of the mailbox register file (PCH or BMC; one instance per port).
- Handles the command-code pointer, auto-increment, waitrequest arbitration stalls, read-latency wait and NACK on invalid writes.
- Sits between the SMBus PHY and the register file's pch_*/bmc_* port.

---
 rtl/smbus_mailbox_avmm_bridge_if.sv | 37 +++
 rtl/smbus_mailbox_avmm_bridge.sv | 165 ++++++++++++++++
 tb/tb_smbus_mailbox_avmm_bridge.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/smbus_mailbox_avmm_bridge_if.sv
// rtl/smbus_mailbox_avmm_bridge_if.sv - SMBus PHY byte events and AVMM register port bundle
interface smbus_mailbox_avmm_bridge_if;
  logic        rx_start;
  logic        rx_rnw;
  logic        rx_stop;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        ack_valid;
  logic        ack;
  logic        tx_byte_req;
  logic        tx_byte_valid;
  logic [7:0]  tx_byte;
  logic        avm_read;
  logic        avm_write;
  logic [7:0]  avm_address;
  logic [7:0]  avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic        avm_invalid_cmd;

  // Bridge side: consumes PHY events, masters the register-file port.
  modport master (
    input  rx_start, rx_rnw, rx_stop, rx_byte_valid, rx_byte, tx_byte_req,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest, avm_invalid_cmd,
    output ack_valid, ack, tx_byte_valid, tx_byte,
    output avm_read, avm_write, avm_address, avm_writedata
  );

  // Environment side: PHY plus register file.
  modport slave (
    output rx_start, rx_rnw, rx_stop, rx_byte_valid, rx_byte, tx_byte_req,
    output avm_readdata, avm_readdatavalid, avm_waitrequest, avm_invalid_cmd,
    input  ack_valid, ack, tx_byte_valid, tx_byte,
    input  avm_read, avm_write, avm_address, avm_writedata
  );
endinterface

// File: rtl/smbus_mailbox_avmm_bridge.sv
// rtl/smbus_mailbox_avmm_bridge.sv - SMBus target byte events to single-beat AVMM mailbox accesses
module smbus_mailbox_avmm_bridge #(
  parameter bit AUTO_INC     = 1'b1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  smbus_mailbox_avmm_bridge_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    WISSUE = 3'd3,
    RDY    = 3'd4,
    RISSUE = 3'd5,
    RWAIT  = 3'd6
  } state_t;

  // Last count value at which a stalled request is still allowed to be held.
  localparam logic [7:0] TMO_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic [7:0] tmo_cnt, tmo_nxt;
  logic [7:0] tx_byte_nxt;
  logic       ack_valid_nxt, ack_nxt, tx_valid_nxt;
  logic       stop_pend, start_pend, rnw_pend;
  logic       stop_pend_nxt, start_pend_nxt, rnw_pend_nxt;
  logic       issuing, accept, tmo_hit, in_flight, completing;
  logic       eff_stop, eff_start, eff_rnw;
  logic       unused_readdata;

  assign issuing   = (state == WISSUE) || (state == RISSUE);
  assign in_flight = issuing || (state == RWAIT);
  assign accept    = issuing && !bus.avm_waitrequest;
  assign tmo_hit   = issuing && bus.avm_waitrequest && (tmo_cnt == TMO_LAST);
  assign completing = ((state == WISSUE) && (accept || tmo_hit)) ||
                      ((state == RISSUE) && tmo_hit) ||
                      ((state == RWAIT) && bus.avm_readdatavalid);

  // Bus events seen during an in-flight access merge with any that arrive in
  // the completion cycle itself; the most recent of START/STOP wins.
  assign eff_stop  = bus.rx_stop || (stop_pend && !bus.rx_start);
  assign eff_start = !bus.rx_stop && (bus.rx_start || start_pend);
  assign eff_rnw   = bus.rx_start ? bus.rx_rnw : rnw_pend;

  assign unused_readdata = ^bus.avm_readdata[31:8];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_t done_target;
    if (eff_stop)       done_target = IDLE;
    else if (eff_start) done_target = eff_rnw ? RDY : CMD;
    else                done_target = (state == WISSUE) ? WDATA : RDY;

    state_nxt = state;
    case (state)
      IDLE:   if (bus.rx_start) state_nxt = bus.rx_rnw ? RDY : CMD;
      CMD:    if (bus.rx_stop) state_nxt = IDLE;
              else if (bus.rx_byte_valid) state_nxt = WDATA;
      WDATA:  if (bus.rx_stop) state_nxt = IDLE;
              else if (bus.rx_start) state_nxt = bus.rx_rnw ? RDY : CMD;
              else if (bus.rx_byte_valid) state_nxt = WISSUE;
      RDY:    if (bus.rx_stop) state_nxt = IDLE;
              else if (bus.rx_start) state_nxt = bus.rx_rnw ? RDY : CMD;
              else if (bus.tx_byte_req) state_nxt = RISSUE;
      WISSUE: if (completing) state_nxt = done_target;
      RISSUE: if (accept) state_nxt = RWAIT;
              else if (tmo_hit) state_nxt = done_target;
      RWAIT:  if (completing) state_nxt = done_target;
      default: state_nxt = IDLE;
    endcase
  end

  // Request outputs and next values of the pointer, data latch and PHY pulses.
  always_comb begin
    bus.avm_write     = (state == WISSUE);
    bus.avm_read      = (state == RISSUE);
    bus.avm_address   = ptr;
    bus.avm_writedata = wdata_q;

    ptr_nxt        = ptr;
    wdata_nxt      = wdata_q;
    ack_valid_nxt  = 1'b0;
    ack_nxt        = bus.ack;
    tx_valid_nxt   = 1'b0;
    tx_byte_nxt    = bus.tx_byte;
    tmo_nxt        = (issuing && bus.avm_waitrequest && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;
    stop_pend_nxt  = 1'b0;
    start_pend_nxt = 1'b0;
    rnw_pend_nxt   = rnw_pend;

    case (state)
      CMD: if (bus.rx_byte_valid && !bus.rx_stop) begin
        ptr_nxt       = bus.rx_byte;
        ack_valid_nxt = 1'b1;
        ack_nxt       = 1'b1;
      end
      WDATA: if (bus.rx_byte_valid && !bus.rx_stop && !bus.rx_start) begin
        wdata_nxt = bus.rx_byte;
      end
      WISSUE: if (accept) begin
        ack_valid_nxt = !eff_stop;
        ack_nxt       = !bus.avm_invalid_cmd;
        if (AUTO_INC && !bus.avm_invalid_cmd) ptr_nxt = ptr + 8'd1;
      end else if (tmo_hit) begin
        ack_valid_nxt = !eff_stop;
        ack_nxt       = 1'b0;
      end
      RISSUE: if (tmo_hit) begin
        tx_valid_nxt = !eff_stop;
        tx_byte_nxt  = 8'hFF;
      end
      RWAIT: if (bus.avm_readdatavalid) begin
        tx_valid_nxt = !eff_stop;
        tx_byte_nxt  = bus.avm_readdata[7:0];
        if (AUTO_INC) ptr_nxt = ptr + 8'd1;
      end
      default: ;
    endcase

    if (in_flight && !completing) begin
      stop_pend_nxt  = eff_stop;
      start_pend_nxt = eff_start;
      if (bus.rx_start) rnw_pend_nxt = bus.rx_rnw;
    end
  end

  // Datapath and registered PHY-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr               <= 8'h00;
      wdata_q           <= 8'h00;
      tmo_cnt           <= 8'h00;
      stop_pend         <= 1'b0;
      start_pend        <= 1'b0;
      rnw_pend          <= 1'b0;
      bus.ack_valid     <= 1'b0;
      bus.ack           <= 1'b0;
      bus.tx_byte_valid <= 1'b0;
      bus.tx_byte       <= 8'h00;
    end else begin
      ptr               <= ptr_nxt;
      wdata_q           <= wdata_nxt;
      tmo_cnt           <= tmo_nxt;
      stop_pend         <= stop_pend_nxt;
      start_pend        <= start_pend_nxt;
      rnw_pend          <= rnw_pend_nxt;
      bus.ack_valid     <= ack_valid_nxt;
      bus.ack           <= ack_nxt;
      bus.tx_byte_valid <= tx_valid_nxt;
      bus.tx_byte       <= tx_byte_nxt;
    end
  end

endmodule

// File: tb/tb_smbus_mailbox_avmm_bridge.sv
// tb/tb_smbus_mailbox_avmm_bridge.sv - directed vector bench for smbus_mailbox_avmm_bridge
module tb_smbus_mailbox_avmm_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   wr_accepts = 0;

  always #5 clk = ~clk;

  smbus_mailbox_avmm_bridge_if bi();
  smbus_mailbox_avmm_bridge_if bt();

  smbus_mailbox_avmm_bridge #(.AUTO_INC(1'b1), .WAIT_TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn), .bus(bi)
  );

  smbus_mailbox_avmm_bridge #(.AUTO_INC(1'b1), .WAIT_TIMEOUT(4)) dut_tmo (
    .clk(clk), .resetn(resetn), .bus(bt)
  );

  assign bt.rx_start          = bi.rx_start;
  assign bt.rx_rnw            = bi.rx_rnw;
  assign bt.rx_stop           = bi.rx_stop;
  assign bt.rx_byte_valid     = bi.rx_byte_valid;
  assign bt.rx_byte           = bi.rx_byte;
  assign bt.tx_byte_req       = bi.tx_byte_req;
  assign bt.avm_readdata      = bi.avm_readdata;
  assign bt.avm_readdatavalid = bi.avm_readdatavalid;
  assign bt.avm_waitrequest   = bi.avm_waitrequest;
  assign bt.avm_invalid_cmd   = bi.avm_invalid_cmd;

  logic unused_bt;
  assign unused_bt = ^{bt.ack_valid, bt.ack, bt.avm_write, bt.avm_writedata};

  // Register file contents as seen by reads (writes do not alter it).
  function automatic logic [7:0] rd_fn(input logic [7:0] a);
    case (a)
      8'hFE:   return 8'h11;
      8'hFF:   return 8'h22;
      8'h00:   return 8'h33;
      default: return ~a;
    endcase
  endfunction

  // One-cycle-latency register file model.
  always @(posedge clk) begin
    bi.avm_readdatavalid <= bi.avm_read && !bi.avm_waitrequest;
    bi.avm_readdata      <= {24'h0, rd_fn(bi.avm_address)};
    if (bi.avm_write && !bi.avm_waitrequest) wr_accepts <= wr_accepts + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pulse_start(input logic rnw);
    bi.rx_start = 1'b1; bi.rx_rnw = rnw;
    @(negedge clk);
    bi.rx_start = 1'b0; bi.rx_rnw = 1'b0;
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    bi.rx_byte_valid = 1'b1; bi.rx_byte = b;
    @(negedge clk);
    bi.rx_byte_valid = 1'b0; bi.rx_byte = 8'h00;
  endtask

  task automatic pulse_stop();
    bi.rx_stop = 1'b1;
    @(negedge clk);
    bi.rx_stop = 1'b0;
  endtask

  task automatic pulse_txreq();
    bi.tx_byte_req = 1'b1;
    @(negedge clk);
    bi.tx_byte_req = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       inv;
    logic       exp_ack;
    logic [7:0] exp_ptr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] burst_addr [3];
    logic [7:0] burst_data [3];

    vecs[0] = '{8'h0A, 8'h55, 1'b0, 1'b1, 8'h0B, 8'hF4};
    vecs[1] = '{8'h00, 8'hAA, 1'b1, 1'b0, 8'h00, 8'h33};
    vecs[2] = '{8'hFF, 8'h3C, 1'b0, 1'b1, 8'h00, 8'h33};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 8'h7F};
    vecs[4] = '{8'h10, 8'h99, 1'b1, 1'b0, 8'h10, 8'hEF};
    burst_addr[0] = 8'hFE; burst_addr[1] = 8'hFF; burst_addr[2] = 8'h00;
    burst_data[0] = 8'h11; burst_data[1] = 8'h22; burst_data[2] = 8'h33;

    bi.rx_start = 1'b0; bi.rx_rnw = 1'b0; bi.rx_stop = 1'b0;
    bi.rx_byte_valid = 1'b0; bi.rx_byte = 8'h00; bi.tx_byte_req = 1'b0;
    bi.avm_waitrequest = 1'b0; bi.avm_invalid_cmd = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {3'b0, bi.ack_valid, bi.ack, bi.tx_byte_valid, bi.tx_byte,
                          bi.avm_read, bi.avm_write, bi.avm_address, bi.avm_writedata}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Write, readback of pointer via repeated-START read, stop.
    for (int i = 0; i < 5; i++) begin
      pulse_start(1'b0);
      pulse_byte(vecs[i].cmd);
      chk($sformatf("v%0d_cmd_ack", i), {bi.ack_valid, bi.ack}, 2'b11);
      bi.avm_invalid_cmd = vecs[i].inv;
      pulse_byte(vecs[i].data);
      chk($sformatf("v%0d_write_req", i), {bi.avm_write, bi.avm_read, bi.avm_address, bi.avm_writedata},
          {2'b10, vecs[i].cmd, vecs[i].data});
      @(negedge clk);
      bi.avm_invalid_cmd = 1'b0;
      chk($sformatf("v%0d_data_ack", i), {bi.ack_valid, bi.ack}, {1'b1, vecs[i].exp_ack});
      pulse_start(1'b1);
      pulse_txreq();
      chk($sformatf("v%0d_read_addr", i), {bi.avm_read, bi.avm_address}, {1'b1, vecs[i].exp_ptr});
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_tx", i), {bi.tx_byte_valid, bi.tx_byte}, {1'b1, vecs[i].exp_rd});
      pulse_stop();
    end

    // Burst read across the 0xFF -> 0x00 wrap, with latency measured.
    pulse_start(1'b0);
    pulse_byte(8'hFE);
    pulse_start(1'b1);
    for (int k = 0; k < 3; k++) begin
      pulse_txreq();
      chk($sformatf("burst%0d_addr", k), {bi.avm_read, bi.avm_address}, {1'b1, burst_addr[k]});
      n = 0;
      while (!bi.tx_byte_valid && n < 10) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("burst%0d_latency", k), n, 2);
      chk($sformatf("burst%0d_data", k), bi.tx_byte, burst_data[k]);
    end
    pulse_stop();

    // Arbitration stall: five waitrequest cycles, then one accept.
    do_reset();
    pulse_start(1'b0);
    pulse_byte(8'h33);
    bi.avm_waitrequest = 1'b1;
    n = wr_accepts;
    pulse_byte(8'hC4);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall%0d_hold", s), {bi.avm_write, bi.ack_valid, bi.avm_address, bi.avm_writedata},
          {2'b10, 8'h33, 8'hC4});
      @(negedge clk);
    end
    bi.avm_waitrequest = 1'b0;
    chk("stall_accept_cycle", {bi.avm_write, bi.ack_valid}, 2'b10);
    @(negedge clk);
    chk("stall_ack", {bi.ack_valid, bi.ack, bi.avm_write}, 3'b110);
    chk("stall_one_accept", wr_accepts - n, 1);
    pulse_stop();

    // Timeout on a read (WAIT_TIMEOUT = 4 instance).
    do_reset();
    pulse_start(1'b0);
    pulse_byte(8'h20);
    pulse_start(1'b1);
    bi.avm_waitrequest = 1'b1;
    pulse_txreq();
    n = 0;
    while (bt.avm_read && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_hold_cycles", n, 4);
    chk("tmo_tx", {bt.tx_byte_valid, bt.tx_byte}, 9'h1FF);
    pulse_txreq();
    chk("tmo_ptr_kept", {bt.avm_read, bt.avm_address}, {1'b1, 8'h20});
    bi.avm_waitrequest = 1'b0;

    // STOP during RWAIT: read completes silently, then IDLE.
    do_reset();
    pulse_start(1'b0);
    pulse_byte(8'h40);
    pulse_start(1'b1);
    pulse_txreq();
    @(negedge clk);
    pulse_stop();
    chk("stop_no_tx0", bi.tx_byte_valid, 1'b0);
    @(negedge clk);
    chk("stop_no_tx1", bi.tx_byte_valid, 1'b0);
    pulse_txreq();
    chk("stop_idle", bi.avm_read, 1'b0);
    pulse_start(1'b1);
    pulse_txreq();
    chk("stop_ptr_retained", {bi.avm_read, bi.avm_address}, {1'b1, 8'h41});
    repeat (2) @(negedge clk);
    pulse_stop();

    // Reset in the middle of a stalled write.
    pulse_start(1'b0);
    pulse_byte(8'h66);
    bi.avm_waitrequest = 1'b1;
    pulse_byte(8'h77);
    chk("rst_pre_write", {bi.avm_write, bi.avm_address}, {1'b1, 8'h66});
    resetn = 1'b0;
    #1;
    chk("rst_async_drop", {bi.avm_write, bi.ack_valid, bi.avm_address}, 10'h0);
    @(negedge clk);
    resetn = 1'b1;
    bi.avm_waitrequest = 1'b0;
    @(negedge clk);
    pulse_start(1'b1);
    pulse_txreq();
    chk("rst_ptr_zero", {bi.avm_read, bi.avm_address}, {1'b1, 8'h00});
    repeat (2) @(negedge clk);
    pulse_stop();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
